// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-request APB master for the slave1/slave2 bus.
// Address bit ADDR_W picks the slave; a stalled ACCESS ends in a timeout.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     wcnt;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  // PSEL2 doubles as the latched slave select while a transfer is live
  assign pready = PSEL2 ? PREADY2 : PREADY1;
  assign prdata = PSEL2 ? PRDATA2 : PRDATA1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            PWRITE    <= req_write;
            PADDR     <= req_addr[ADDR_W-1:0];
            PWDATA    <= req_wdata;
            PSEL1     <= !req_addr[ADDR_W];
            PSEL2     <= req_addr[ADDR_W];
            wcnt      <= '0;
            state     <= SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || wcnt == WLAST) begin
            state     <= IDLE;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= !pready;
            rsp_rdata <= (pready && !PWRITE) ? prdata : '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          PSEL1     <= 1'b0;
          PSEL2     <= 1'b0;
          PENABLE   <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed plus random transfers against
// a memory-backed slave model and cycle-accurate expectations.
module tb_apb_master_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA1, PRDATA2;
  logic          PREADY1, PREADY2;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [2][256];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input string tag);
    chk({tag, "_psel1"}, PSEL1, 0);
    chk({tag, "_psel2"}, PSEL2, 0);
    chk({tag, "_penable"}, PENABLE, 0);
  endtask

  // One transfer; the selected slave raises PREADY after `waits` stalls.
  task automatic xfer(input bit wr, input logic [AW:0] a,
                      input logic [DW-1:0] d, input int waits,
                      input bit b2b);
    bit s;
    bit err;
    int n;
    int acc;
    logic [AW-1:0] pa;
    logic [DW-1:0] exp_rd;
    s = a[AW];
    pa = a[AW-1:0];
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 10, 1);
    if (b2b) chk("b2b_ready_gap", n, 0);
    if (n >= 10) return;
    @(negedge clk);
    if (!b2b) req_valid = 1'b0;
    chk("setup_psel1", PSEL1, !s);
    chk("setup_psel2", PSEL2, s);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, pa);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, d);
    chk("setup_ready", req_ready, 0);
    chk("setup_rsp", rsp_valid, 0);
    err = waits >= TO;
    exp_rd = (wr || err) ? '0 : mem[s][pa];
    acc = err ? TO : waits + 1;
    for (int i = 0; i < acc; i++) begin
      @(negedge clk);
      chk("acc_penable", PENABLE, 1);
      chk("acc_psel1", PSEL1, !s);
      chk("acc_psel2", PSEL2, s);
      chk("acc_paddr", PADDR, pa);
      chk("acc_pwdata", PWDATA, d);
      chk("acc_pwrite", PWRITE, wr);
      chk("acc_ready", req_ready, 0);
      chk("acc_rsp", rsp_valid, 0);
      if (s) begin
        PREADY2 = (i == waits);
        PRDATA2 = (i == waits) ? mem[1][pa] : 8'($urandom);
        PREADY1 = 1'($urandom);
        PRDATA1 = 8'($urandom);
      end else begin
        PREADY1 = (i == waits);
        PRDATA1 = (i == waits) ? mem[0][pa] : 8'($urandom);
        PREADY2 = 1'($urandom);
        PRDATA2 = 8'($urandom);
      end
    end
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_paddr_hold", PADDR, pa);
    chk("rsp_ready", req_ready, 1);
    bus_idle("rsp");
    if (wr && !err) mem[s][pa] = d;
    PREADY1 = 1'b0;
    PREADY2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] ra;
    int w;
    for (int k = 0; k < 256; k++) begin
      mem[0][k] = 8'($urandom);
      mem[1][k] = 8'($urandom);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    PRDATA1 = '0;
    PRDATA2 = '0;
    PREADY1 = 1'b0;
    PREADY2 = 1'b0;
    #1;
    bus_idle("reset");
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp", rsp_valid, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_pwrite", PWRITE, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    chk("reset_hold_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);

    xfer(1'b1, 9'h005, 8'hA5, 0, 1'b0);
    xfer(1'b1, 9'h102, 8'h3C, 0, 1'b0);
    xfer(1'b0, 9'h102, 8'h77, 0, 1'b0);
    chk("s2_readback", rsp_rdata, 8'h3C);

    for (int k = 0; k < 4; k++) begin
      ra = 9'($urandom);
      xfer(1'b0, ra, 8'($urandom), 0, 1'b1);
    end
    req_valid = 1'b0;

    xfer(1'b0, 9'h1A0, 8'h00, 3, 1'b0);
    xfer(1'b0, 9'h1A1, 8'h00, TO - 1, 1'b0);
    xfer(1'b0, 9'h1A2, 8'h00, TO, 1'b0);
    xfer(1'b1, 9'h1A3, 8'h5A, TO + 10, 1'b0);
    xfer(1'b0, 9'h1A3, 8'h00, 0, 1'b0);

    // abort a write in ACCESS; it must not land or respond
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 9'h033;
    req_wdata = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", PENABLE, 1);
    #2 reset = 1'b0;
    #1;
    bus_idle("abort");
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_ready", req_ready, 0);
    @(negedge clk);
    chk("abort_rsp_hold", rsp_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_after", rsp_valid, 0);
    xfer(1'b0, 9'h033, 8'h00, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = 9'($urandom);
      w = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3)
                                      : $urandom_range(0, 5);
      xfer(1'($urandom), ra, 8'($urandom), w, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
